hx711_zynq_axil_slave: RTL

- AXI4-Lite slave register file for the HX711 load-cell interface in the SmartCanteen PL.
- Answers the PS/master-VIP AXI4-Lite writes and reads to four 32-bit registers at word offsets 0x0, 0x4, 0x8, 0xC.
- Captures 24-bit conversion results from the HX711 serial core, applies tare subtraction and exposes them to software.
- Drives the core's enable and gain-select controls.

---
 rtl/hx711_zynq_axil_slave.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/hx711_zynq_axil_slave.sv
// AXI4-Lite register file for the HX711 load-cell core: CTRL, STATUS, DATA (tared sample), OFFSET.
// Define HX711_AXIL_SLVERR_EN to answer writes to read-only locations with SLVERR.
module hx711_zynq_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int SAMPLE_BITS        = 24
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [(C_S_AXI_DATA_WIDTH/8)-1:0] s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    input  logic [SAMPLE_BITS-1:0]            sample_data,
    input  logic                              sample_valid,
    output logic                              hx_enable,
    output logic [1:0]                        hx_gain,
    output logic                              irq
);

    localparam int EXT_BITS = C_S_AXI_DATA_WIDTH - SAMPLE_BITS;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DATA    = 2'd2;
    localparam logic [1:0] REG_OFFSET  = 2'd3;

    logic                          awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]                    bresp_q;
    logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q, readMux;
    logic [3:0]                    ctrl_q, ctrl_d;
    logic [C_S_AXI_DATA_WIDTH-1:0] offset_q, offset_d, data_q, data_d;
    logic                          valid_q, valid_d, overrun_q, overrun_d;
    logic                          wrFire, rdFire, sampleFire, wrErr;
    logic [1:0]                    wrSel, rdSel;
    logic [C_S_AXI_DATA_WIDTH-1:0] sampleExt;
    logic                          unusedBits;

    assign wrSel      = s00_axi_awaddr[3:2];
    assign rdSel      = s00_axi_araddr[3:2];
    assign wrFire     = awready_q & wready_q & s00_axi_awvalid & s00_axi_wvalid;
    assign rdFire     = arready_q & s00_axi_arvalid;
    assign sampleFire = sample_valid & ctrl_q[0];
    assign sampleExt  = {{EXT_BITS{sample_data[SAMPLE_BITS-1]}}, sample_data};
    assign unusedBits = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

`ifdef HX711_AXIL_SLVERR_EN
    assign wrErr = (wrSel == REG_DATA) || ((wrSel == REG_STATUS) && !s00_axi_wstrb[0]);
`else
    assign wrErr = 1'b0;
`endif

    // Handshake state: write readies pulse once per transaction and are blocked while a response is pending.
    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
        end else begin
            awready_q <= s00_axi_awvalid & s00_axi_wvalid & ~bvalid_q & ~awready_q & ~wready_q;
            wready_q  <= s00_axi_awvalid & s00_axi_wvalid & ~bvalid_q & ~awready_q & ~wready_q;
            if (wrFire) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wrErr ? RESP_SLVERR : RESP_OKAY;
            end else if (bvalid_q && s00_axi_bready) begin
                bvalid_q <= 1'b0;
            end
            arready_q <= s00_axi_arvalid & ~rvalid_q & ~arready_q;
            if (rdFire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= readMux;
            end else if (rvalid_q && s00_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        readMux = '0;
        case (rdSel)
            REG_CTRL:   readMux[3:0] = ctrl_q;
            REG_STATUS: readMux[1:0] = {overrun_q, valid_q};
            REG_DATA:   readMux      = data_q;
            default:    readMux      = offset_q;
        endcase
    end

    // Sample capture is applied after software effects so a new sample's set beats a read-clear or W1C.
    always_comb begin
        ctrl_d    = ctrl_q;
        offset_d  = offset_q;
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (wrFire && !wrErr) begin
            case (wrSel)
                REG_CTRL:   if (s00_axi_wstrb[0]) ctrl_d = s00_axi_wdata[3:0];
                REG_STATUS: if (s00_axi_wstrb[0] && s00_axi_wdata[1]) overrun_d = 1'b0;
                REG_OFFSET: begin
                    for (int b = 0; b < C_S_AXI_DATA_WIDTH / 8; b++) begin
                        if (s00_axi_wstrb[b]) offset_d[8*b +: 8] = s00_axi_wdata[8*b +: 8];
                    end
                end
                default: ;
            endcase
        end
        if (rdFire && (rdSel == REG_DATA)) valid_d = 1'b0;
        if (sampleFire) begin
            data_d  = sampleExt - offset_q;
            valid_d = 1'b1;
            if (valid_q) overrun_d = 1'b1;
        end
    end

    always_ff @(posedge s00_axi_aclk) begin
        if (!s00_axi_aresetn) begin
            ctrl_q    <= '0;
            offset_q  <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            offset_q  <= offset_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign s00_axi_awready = awready_q;
    assign s00_axi_wready  = wready_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_arready = arready_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rdata   = rdata_q;
    assign s00_axi_rresp   = RESP_OKAY;
    assign hx_enable       = ctrl_q[0];
    assign hx_gain         = ctrl_q[2:1];
    assign irq             = valid_q & ctrl_q[3];

endmodule
